// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer and the ROM image generator.
// Optional interrupt dispatch is enabled by defining MICROSEQ_INT_DISPATCH_EN.
package microcode_pkg;

  localparam int DEF_UADDR_W = 9;
  localparam logic [8:0] INT_UADDR_DEFAULT = 9'h0D3;

  // Control-word field positions; must match the ROM image generator.
  localparam int CTRL_END     = 63;
  localparam int CTRL_NEXT_HI = 62;
  localparam int CTRL_NEXT_LO = 54;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CB_FETCH,
    ST_EXEC
  } seq_state_t;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Opcode-fetch handshake plus the ROM address/control-word loop.
// The master side is the sequencer; the slave side is fetch path plus ROM.
interface microcode_sequencer_if
  import microcode_pkg::*;
#(
  parameter int UADDR_W = DEF_UADDR_W
);
  logic               fetch_req;
  logic               fetch_valid;
  logic [7:0]         fetch_data;
  logic [UADDR_W-1:0] uaddr;
  logic [63:0]        ctrl;

  modport master (
    output fetch_req,
    output uaddr,
    input  fetch_valid,
    input  fetch_data,
    input  ctrl
  );

  modport slave (
    input  fetch_req,
    input  uaddr,
    output fetch_valid,
    output fetch_data,
    output ctrl
  );
endinterface

// File: rtl/microcode_sequencer_mcycle_timer.sv
// T-cycle counter: 2-bit wrap, one M-cycle = 4 clocks, commit strobe on T3.
// Latency: commit is combinational from the count and stall; stall freezes the count.
module mcycle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       stall,
  input  logic       clr,
  output logic [1:0] tcycle,
  output logic       commit
);

  logic [1:0] tcycle_q, tcycle_d;

  always_comb begin
    tcycle_d = tcycle_q;
    if (clr) begin
      tcycle_d = 2'd0;
    end else if (en && !stall) begin
      tcycle_d = tcycle_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcycle_q <= 2'd0;
    end else begin
      tcycle_q <= tcycle_d;
    end
  end

  assign tcycle = tcycle_q;
  assign commit = en & ~stall & (tcycle_q == 2'd3);

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches opcodes (0xCB folds into addr bit 8), steps micro-ops from ROM next/end.
// Latency: byte accepted at edge N -> EXEC in N+1; 4 clocks per micro-op plus stalls. Macro: MICROSEQ_INT_DISPATCH_EN.
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int                 UADDR_W   = DEF_UADDR_W,
  parameter logic [UADDR_W-1:0] INT_UADDR = UADDR_W'(INT_UADDR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  microcode_sequencer_if.master bus,
  input  logic                  mem_stall,
  output logic [1:0]            tcycle,
  output logic                  step,
  output logic                  busy,
  input  logic                  int_req,
  output logic                  int_ack
);

  seq_state_t         state_q, state_d;
  logic [UADDR_W-1:0] uaddr_q, uaddr_d;
  logic               fetch_req_q, fetch_req_d;
  logic               busy_q, busy_d;
  logic               int_ack_q, int_ack_d;
  logic               xfer;
  logic               commit;
  logic [8:0]         next_uaddr;

  // fetch_req_q is high exactly in FETCH/CB_FETCH, so it doubles as the state qualifier.
  assign xfer       = fetch_req_q & bus.fetch_valid;
  assign next_uaddr = bus.ctrl[CTRL_NEXT_HI:CTRL_NEXT_LO];

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^bus.ctrl[CTRL_NEXT_LO-1:0];

  mcycle_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (busy_q),
    .stall  (mem_stall),
    .clr    (~busy_q),
    .tcycle (tcycle),
    .commit (commit)
  );

  always_comb begin
    state_d   = state_q;
    uaddr_d   = uaddr_q;
    int_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (xfer) begin
          if (bus.fetch_data == CB_PREFIX) begin
            state_d = ST_CB_FETCH;
          end else begin
            uaddr_d = UADDR_W'({1'b0, bus.fetch_data});
            state_d = ST_EXEC;
          end
        end
      end
      ST_CB_FETCH: begin
        if (xfer) begin
          uaddr_d = UADDR_W'({1'b1, bus.fetch_data});
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (commit) begin
          if (!bus.ctrl[CTRL_END]) begin
            uaddr_d = UADDR_W'(next_uaddr);
          end else begin
`ifdef MICROSEQ_INT_DISPATCH_EN
            // Timer wraps 3->0 on this commit, so the handler starts at T0.
            if (int_req) begin
              uaddr_d   = INT_UADDR;
              int_ack_d = 1'b1;
            end else begin
              state_d = ST_FETCH;
            end
`else
            state_d = ST_FETCH;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fetch_req_d = (state_d == ST_FETCH) || (state_d == ST_CB_FETCH);
    busy_d      = (state_d == ST_EXEC);
  end

`ifndef MICROSEQ_INT_DISPATCH_EN
  logic unused_int_req;
  assign unused_int_req = int_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      uaddr_q     <= '0;
      fetch_req_q <= 1'b0;
      busy_q      <= 1'b0;
      int_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      uaddr_q     <= uaddr_d;
      fetch_req_q <= fetch_req_d;
      busy_q      <= busy_d;
      int_ack_q   <= int_ack_d;
    end
  end

  assign bus.fetch_req = fetch_req_q;
  assign bus.uaddr     = uaddr_q;
  assign busy          = busy_q;
  assign step          = commit;
  assign int_ack       = int_ack_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: opcode vector table, ROM model, step scoreboard.
module tb_microcode_sequencer;
  import microcode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_stall = 1'b0;
  logic       int_req = 1'b0;
  logic [1:0] tcycle;
  logic       step;
  logic       busy;
  logic       int_ack;

  microcode_sequencer_if #(.UADDR_W(9)) bus ();

  microcode_sequencer #(.UADDR_W(9), .INT_UADDR(9'h0D3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_stall (mem_stall),
    .tcycle    (tcycle),
    .step      (step),
    .busy      (busy),
    .int_req   (int_req),
    .int_ack   (int_ack)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] sb[$];
  int         exp_len = 4;
  int         op_len = 0;
  int         step_total = 0;
  int         ack_total = 0;

  // ROM image: unlisted addresses end immediately with a junk NEXT field.
  function automatic logic [63:0] rom_word(input logic [8:0] a);
    logic [63:0] w;
    w = {1'b1, 9'h155, 54'h2AAAA5555A5A5};
    case (a)
      9'h0C3: begin w[63] = 1'b0; w[62:54] = 9'h1F0; end
      9'h010: begin w[63] = 1'b0; w[62:54] = 9'h011; end
      9'h011: begin w[63] = 1'b0; w[62:54] = 9'h012; end
      default: ;
    endcase
    return w;
  endfunction

  always_comb bus.ctrl = rom_word(bus.uaddr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void push_walk(input logic [8:0] entry);
    logic [8:0]  a;
    logic [63:0] w;
    a = entry;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(a);
      w = rom_word(a);
      if (w[63]) break;
      a = w[62:54];
    end
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      op_len = 0;
    end else begin
      if (int_ack) ack_total++;
      if (busy) begin
        op_len++;
        if (step) begin
          step_total++;
          if (sb.size() > 0) e = 64'(sb.pop_front());
          else e = 'x;
          chk("step_uaddr", 64'(bus.uaddr), e);
          chk("step_tcycle", 64'(tcycle), 64'd3);
          chk("op_len", 64'(op_len), 64'(exp_len));
          op_len = 0;
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_uaddr"}, 64'(bus.uaddr), 64'd0);
    chk({tag, "_tcycle"}, 64'(tcycle), 64'd0);
    chk({tag, "_fetch_req"}, 64'(bus.fetch_req), 64'd0);
    chk({tag, "_step"}, 64'(step), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_int_ack"}, 64'(int_ack), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    bus.fetch_data  = b;
    bus.fetch_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      waits++;
      if (bus.fetch_req) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    bus.fetch_valid = 1'b0;
    chk("fetch_handshake", 64'(got), 64'd1);
  endtask

  task automatic wait_fetch(output int n);
    n = 0;
    while (!bus.fetch_req && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.fetch_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b0;
    bit         cb;
    logic [7:0] b1;
    logic [8:0] exp_entry;
    int         exp_steps;
    logic [8:0] exp_final;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int s0, n, w;
    s0 = step_total;
    if (v.cb) begin
      send_byte(8'hCB, w);
      chk("cb_no_exec", 64'(busy), 64'd0);
      chk("cb_fetch_req", 64'(bus.fetch_req), 64'd1);
      send_byte(v.b1, w);
    end else begin
      send_byte(v.b0, w);
    end
    push_walk(v.exp_entry);
    if (idx > 0) chk("b2b_first_try", 64'(w), 64'd1);
    chk("entry_uaddr", 64'(bus.uaddr), 64'(v.exp_entry));
    chk("entry_busy", 64'(busy), 64'd1);
    chk("entry_tcycle", 64'(tcycle), 64'd0);
    chk("entry_fetch_req", 64'(bus.fetch_req), 64'd0);
    // A byte offered during EXEC must not be consumed.
    bus.fetch_data  = 8'h55;
    bus.fetch_valid = 1'b1;
    wait_fetch(n);
    chk("exec_cycles", 64'(n), 64'(4 * v.exp_steps));
    chk("steps", 64'(step_total - s0), 64'(v.exp_steps));
    chk("final_uaddr", 64'(bus.uaddr), 64'(v.exp_final));
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic stall_op(input int at_tc, input int ncyc);
    int s0, n, k, w;
    s0 = step_total;
    exp_len = 4 + ncyc;
    send_byte(8'h00, w);
    push_walk(9'h000);
    k = 0;
    while (k < 4 && tcycle != 2'(at_tc)) begin
      @(posedge clk);
      #1;
      k++;
    end
    mem_stall = 1'b1;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
    end
    chk("stall_tcycle_hold", 64'(tcycle), 64'(at_tc));
    chk("stall_no_step", 64'(step_total - s0), 64'd0);
    mem_stall = 1'b0;
    wait_fetch(n);
    chk("stall_cycles", 64'(k + ncyc + n), 64'(4 + ncyc));
    chk("stall_steps", 64'(step_total - s0), 64'd1);
    exp_len = 4;
  endtask

  task automatic int_test();
    int s0, a0, n, w;
    s0 = step_total;
    a0 = ack_total;
    int_req = 1'b1;
    send_byte(8'h00, w);
    push_walk(9'h000);
`ifdef MICROSEQ_INT_DISPATCH_EN
    begin
      bit found;
      push_walk(9'h0D3);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
        @(negedge clk);
        if (int_ack) begin
          found = 1'b1;
          chk("ack_uaddr", 64'(bus.uaddr), 64'h0D3);
          chk("ack_busy", 64'(busy), 64'd1);
          chk("ack_no_fetch", 64'(bus.fetch_req), 64'd0);
        end
      end
      chk("ack_seen", 64'(found), 64'd1);
      @(posedge clk);
      #1;
      int_req = 1'b0;
      wait_fetch(n);
      chk("int_steps", 64'(step_total - s0), 64'd2);
      chk("int_ack_count", 64'(ack_total - a0), 64'd1);
      chk("int_final_uaddr", 64'(bus.uaddr), 64'h0D3);
    end
`else
    wait_fetch(n);
    int_req = 1'b0;
    chk("noint_cycles", 64'(n), 64'd4);
    chk("noint_steps", 64'(step_total - s0), 64'd1);
    chk("noint_ack_count", 64'(ack_total - a0), 64'd0);
    chk("noint_final_uaddr", 64'(bus.uaddr), 64'h000);
`endif
  endtask

  task automatic reset_mid_exec();
    int s0, k, w;
    send_byte(8'hC3, w);
    push_walk(9'h0C3);
    k = 0;
    while (k < 4 && tcycle != 2'd2) begin
      @(posedge clk);
      #1;
      k++;
    end
    s0 = step_total;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk);
    #1;
    chk("rst_no_step", 64'(step_total - s0), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    chk("rst_rel_idle", 64'(bus.fetch_req), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_rel_fetch", 64'(bus.fetch_req), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h00, 1'b0, 8'h00, 9'h000, 1, 9'h000};
    vecs[1] = '{8'h00, 1'b1, 8'h37, 9'h137, 1, 9'h137};
    vecs[2] = '{8'hC3, 1'b0, 8'h00, 9'h0C3, 2, 9'h1F0};
    vecs[3] = '{8'h00, 1'b1, 8'hCB, 9'h1CB, 1, 9'h1CB};
    vecs[4] = '{8'h10, 1'b0, 8'h00, 9'h010, 3, 9'h012};
    vecs[5] = '{8'h00, 1'b1, 8'hC3, 9'h1C3, 1, 9'h1C3};
    vecs[6] = '{8'hFF, 1'b0, 8'h00, 9'h0FF, 1, 9'h0FF};

    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 8'h00;
    #12;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rel_idle_fetch_req", 64'(bus.fetch_req), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_fetch_req", 64'(bus.fetch_req), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    stall_op(2, 3);
    stall_op(3, 2);
    int_test();
    reset_mid_exec();
    run_vec(vecs[2], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
